neuron_seq_mac: RTL and testbench
=================================

# neuron_seq_mac

Parametrised, time-multiplexed successor to the fully parallel 60-input neuron. It replaces N_IN parallel multipliers with one sign-magnitude multiply-accumulate unit. Samples stream in one per cycle over a valid/ready handshake, and weights and bias sit in a runtime-writable register file. Each finished pre-activation sum is presented as magnitude plus sign, the same form the existing Sigmoid_LUT consumes, over a valid/ready output.

## Interface

Parameters:
- N_IN, 60, inputs per neuron (≥2)
- W, 16, sample/weight width; weight bit W-1 = sign, W-2:0 = magnitude
- FRAC, 12, fractional bits of weights and samples
- ACC_W, 22, output magnitude width
- BIAS_MAG, 22'd39236, reset bias magnitude (ACC_W bits)
- BIAS_NEG, 1'b0, reset bias sign

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample valid
- in_ready  out  1  sample accepted when in_valid && in_ready
- in_data  in  W  unsigned sample
- w_we  in  1  weight/bias write strobe
- w_addr  in  $clog2(N_IN+1)  0..N_IN-1 = weight, N_IN = bias
- w_data  in  ACC_W+1  weight: low W bits used; bias: bit ACC_W = sign, ACC_W-1:0 = magnitude
- w_err  out  1  one-cycle pulse: write dropped
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_sum  out  ACC_W  saturated |sum|
- out_sign  out  1  1 = negative (same meaning as the LUT's predznak)
- out_sat  out  1  magnitude was clipped

## Operation

- FSM states: ACC, FIN, OUT. Reset state: ACC, count = 0, acc = 0.
- ACC:
  - in_ready = 1.
  - On accept, compute p = (w[count][W-2:0] × in_data) >> FRAC, truncated.
  - acc ± p according to w[count][W-1], then count++.
  - On accepting sample count == N_IN-1, go to FIN.
- FIN (1 cycle):
  - in_ready = 0.
  - s = acc ± bias.
  - Register out_sign = (s < 0) and out_sum = min(|s|, 2^ACC_W − 1); out_sat = 1 if clipped.
  - Go to OUT.
- OUT:
  - out_valid = 1; outputs held stable until out_ready.
  - On handshake: go to ACC, acc = 0, count = 0.
  - out_valid falls and in_ready rises in the next cycle.
- Zero result: out_sign = 0 (no negative zero).
- acc is signed, width ACC_W + $clog2(N_IN) + 2, so it cannot wrap before saturation.
- Weight/bias write:
  - Honoured only in ACC with count == 0; takes effect at that edge.
  - Any other time, or w_addr > N_IN: write dropped, w_err pulses the next cycle.
- Write and sample accept on the same edge in ACC with count == 0: the write lands and the sample uses the old w[0].
- Weight sign with zero magnitude contributes 0.

## Timing

- Reset values:
  - in_ready = 1 after reset release; out_valid = 0, out_sum = 0, out_sign = 0, out_sat = 0, w_err = 0.
  - All weights 0; bias = {BIAS_NEG, BIAS_MAG}.
- Throughput: one sample per cycle in ACC. Gaps in in_valid stall the accumulation and do not lose state.
- Latency: the last sample is accepted at edge k. FIN computes at edge k+1. out_valid is high from edge k+1.
- Minimum period per vector: N_IN + 2 cycles, with out_ready tied high.
- Reset mid-vector or during OUT: immediate abort. All state, weights and bias return to reset values, and out_valid drops asynchronously.
- out_ready while out_valid = 0 is ignored.

## Test plan

- Defaults, N_IN = 4, FRAC = 12:
  - Set weights = 0x1000 (+1.0) and bias = +0. Stream samples 0x1000, 0x2000, 0x0800, 0x0800.
  - Expect out_sum = 0x4000, out_sign = 0, out_sat = 0, out_valid rising at edge k+1.
- Mixed signs:
  - Weights {+1.0, −1.0, +0.5 (0x0800), −0.5 (0x8800)}, samples all 0x2000, bias = −0x0100.
  - Sum = 0x2000 − 0x2000 + 0x1000 − 0x1000 − 0x100, so expect out_sum = 0x0100, out_sign = 1.
- Saturation:
  - All weights 0x7FFF, samples 0xFFFF, ACC_W = 16.
  - Expect out_sum = 0xFFFF, out_sat = 1.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles after out_valid.
  - Expect outputs stable and in_ready = 0 throughout. The handshake on cycle 11 restores in_ready on the next cycle.
- Write rules:
  - A write at count = 2 produces a w_err pulse, and the next vector uses the old weight.
  - A write with w_addr = N_IN at idle changes the bias, and the result shifts by exactly the bias delta.
- Async reset after 2 of 4 samples:
  - Expect out_valid = 0 and in_ready = 1 after release.
  - A fresh 4-sample vector produces a result with no contribution from the aborted samples and uses zero weights (result = reset bias).

Source files
------------

// File: rtl/neuron_seq_mac.sv
// Time-multiplexed neuron: one sign-magnitude MAC per accepted sample, a runtime-writable
// weight/bias register file, and a saturated magnitude+sign result over valid/ready.
module neuron_seq_mac #(
   parameter int               N_IN     = 60,
   parameter int               W        = 16,
   parameter int               FRAC     = 12,
   parameter int               ACC_W    = 22,
   parameter logic [ACC_W-1:0] BIAS_MAG = 22'd39236,
   parameter logic             BIAS_NEG = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [W-1:0]               in_data,
   input  logic                       w_we,
   input  logic [$clog2(N_IN+1)-1:0]  w_addr,
   input  logic [ACC_W:0]             w_data,
   output logic                       w_err,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ACC_W-1:0]           out_sum,
   output logic                       out_sign,
   output logic                       out_sat
);

   // Handshakes: a sample moves on an edge where in_valid && in_ready; a result moves on an
   // edge where out_valid && out_ready. in_ready is high only in ACC, out_valid only in OUT.

   localparam int AW       = $clog2(N_IN + 1);
   localparam int CW       = $clog2(N_IN);
   localparam int PW       = 2 * W - 1 - FRAC;
   localparam int ACC_MIN  = ACC_W + CW + 2;
   localparam int PROD_MIN = PW + CW + 2;
   // The accumulator also covers N_IN full-scale products, so saturation always sees the true sum.
   localparam int AAW      = (ACC_MIN > PROD_MIN) ? ACC_MIN : PROD_MIN;
   localparam int SW       = AAW + 1;

   typedef enum logic [1:0] {ST_ACC, ST_FIN, ST_OUT} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           count_q, count_d;
   logic signed [AAW-1:0]   acc_q, acc_d;
   logic [W-1:0]            w_q [N_IN];
   logic [W-1:0]            w_d [N_IN];
   logic [ACC_W-1:0]        bias_mag_q, bias_mag_d;
   logic                    bias_neg_q, bias_neg_d;
   logic [ACC_W-1:0]        out_sum_q, out_sum_d;
   logic                    out_sign_q, out_sign_d;
   logic                    out_sat_q, out_sat_d;
   logic                    w_err_q, w_err_d;

   logic [W-1:0]            w_cur;
   logic [2*W-2:0]          prod;
   logic signed [AAW-1:0]   p_ext;
   logic signed [SW-1:0]    acc_ext;
   logic signed [SW-1:0]    bias_ext;
   logic signed [SW-1:0]    sum_s;
   logic [SW-1:0]           sum_abs;
   logic                    clip;
   logic                    wr_ok;

   assign w_cur    = w_q[count_q];
   assign prod     = (2*W-1)'(w_cur[W-2:0]) * (2*W-1)'(in_data);
   assign p_ext    = $signed(AAW'(prod >> FRAC));
   assign acc_ext  = $signed({acc_q[AAW-1], acc_q});
   assign bias_ext = $signed(SW'(bias_mag_q));
   assign sum_s    = bias_neg_q ? (acc_ext - bias_ext) : (acc_ext + bias_ext);
   assign sum_abs  = sum_s[SW-1] ? $unsigned(-sum_s) : $unsigned(sum_s);
   assign clip     = |sum_abs[SW-1:ACC_W];
   // The register file only changes between vectors, so a vector never mixes old and new weights.
   assign wr_ok    = w_we && (state_q == ST_ACC) && (count_q == '0) && (w_addr <= AW'(N_IN));

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      acc_d      = acc_q;
      w_d        = w_q;
      bias_mag_d = bias_mag_q;
      bias_neg_d = bias_neg_q;
      out_sum_d  = out_sum_q;
      out_sign_d = out_sign_q;
      out_sat_d  = out_sat_q;
      w_err_d    = w_we && !wr_ok;

      for (int i = 0; i < N_IN; i++) begin
         if (wr_ok && (w_addr == AW'(i))) w_d[i] = w_data[W-1:0];
      end
      if (wr_ok && (w_addr == AW'(N_IN))) begin
         bias_neg_d = w_data[ACC_W];
         bias_mag_d = w_data[ACC_W-1:0];
      end

      case (state_q)
         ST_ACC: begin
            if (in_valid) begin
               acc_d = w_cur[W-1] ? (acc_q - p_ext) : (acc_q + p_ext);
               if (count_q == CW'(N_IN - 1)) begin
                  count_d = '0;
                  state_d = ST_FIN;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         ST_FIN: begin
            out_sign_d = sum_s[SW-1];
            out_sum_d  = clip ? '1 : sum_abs[ACC_W-1:0];
            out_sat_d  = clip;
            state_d    = ST_OUT;
         end
         ST_OUT: begin
            if (out_ready) begin
               state_d = ST_ACC;
               acc_d   = '0;
               count_d = '0;
            end
         end
         default: state_d = ST_ACC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_ACC;
         count_q    <= '0;
         acc_q      <= '0;
         w_q        <= '{default: '0};
         bias_mag_q <= BIAS_MAG;
         bias_neg_q <= BIAS_NEG;
         out_sum_q  <= '0;
         out_sign_q <= 1'b0;
         out_sat_q  <= 1'b0;
         w_err_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         acc_q      <= acc_d;
         w_q        <= w_d;
         bias_mag_q <= bias_mag_d;
         bias_neg_q <= bias_neg_d;
         out_sum_q  <= out_sum_d;
         out_sign_q <= out_sign_d;
         out_sat_q  <= out_sat_d;
         w_err_q    <= w_err_d;
      end
   end

   assign in_ready  = (state_q == ST_ACC);
   assign out_valid = (state_q == ST_OUT);
   assign out_sum   = out_sum_q;
   assign out_sign  = out_sign_q;
   assign out_sat   = out_sat_q;
   assign w_err     = w_err_q;

endmodule

// File: tb/tb_neuron_seq_mac.sv
// Bench for neuron_seq_mac (N_IN=4, ACC_W=16): directed and random vectors against a
// plain-arithmetic neuron model, with a queue-based scoreboard checked by a separate monitor.
module tb_neuron_seq_mac;

   localparam int N_IN  = 4;
   localparam int W     = 16;
   localparam int FRAC  = 12;
   localparam int ACC_W = 16;
   localparam int AW    = $clog2(N_IN + 1);
   localparam logic [ACC_W-1:0] RST_BIAS = 16'd39236;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [W-1:0]      in_data;
   logic              w_we;
   logic [AW-1:0]     w_addr;
   logic [ACC_W:0]    w_data;
   logic              w_err;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic              out_sign;
   logic              out_sat;

   neuron_seq_mac #(
      .N_IN(N_IN), .W(W), .FRAC(FRAC), .ACC_W(ACC_W),
      .BIAS_MAG(RST_BIAS), .BIAS_NEG(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_err(w_err),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_sign(out_sign), .out_sat(out_sat)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- counters, model state, scoreboard ----------------
   int n_vectors = 0;
   int n_checks  = 0;
   int n_fail    = 0;

   logic [ACC_W+1:0] exp_q[$];   // {sat, sign, sum}
   logic [ACC_W+1:0] mon_e;

   logic [W-1:0]     m_w [N_IN];
   logic             m_bneg;
   logic [ACC_W-1:0] m_bmag;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic note_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event not seen within its bound at %0t", name, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_IN; i++) m_w[i] = '0;
      m_bneg = 1'b0;
      m_bmag = RST_BIAS;
   endtask

   // Signed dot product of sign-magnitude weights with unsigned samples plus bias, then clip.
   function automatic logic [ACC_W+1:0] model_result(input logic [W-1:0] ws[N_IN],
                                                     input logic [W-1:0] xs[N_IN]);
      longint s;
      longint p;
      longint mag;
      logic   neg;
      logic [ACC_W-1:0] mag_v;
      s = 0;
      for (int i = 0; i < N_IN; i++) begin
         p = (longint'(ws[i] & 16'h7FFF) * longint'(xs[i])) >> FRAC;
         s = ws[i][W-1] ? s - p : s + p;
      end
      s   = m_bneg ? s - longint'(m_bmag) : s + longint'(m_bmag);
      neg = (s < 0);
      mag = neg ? -s : s;
      if (mag > ((longint'(1) << ACC_W) - 1)) return {1'b1, neg, {ACC_W{1'b1}}};
      mag_v = mag[ACC_W-1:0];
      return {1'b0, neg, mag_v};
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            note_fail("unexpected_output");
         end else begin
            mon_e = exp_q.pop_front();
            check("out_sum",  out_sum,  mon_e[ACC_W-1:0]);
            check("out_sign", out_sign, mon_e[ACC_W]);
            check("out_sat",  out_sat,  mon_e[ACC_W+1]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_sample(input logic [W-1:0] x);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = x;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         done = in_ready;
         tick();
      end
      in_valid = 1'b0;
      if (!done) note_fail("sample_accept");
   endtask

   task automatic send_vec(input logic [W-1:0] xs[N_IN], input bit gaps, input bit chk_lat);
      exp_q.push_back(model_result(m_w, xs));
      n_vectors++;
      for (int i = 0; i < N_IN; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         send_sample(xs[i]);
      end
      if (chk_lat) begin
         @(negedge clk);
         check("fin_out_valid", out_valid, 0);
         check("fin_in_ready",  in_ready,  0);
         @(negedge clk);
         check("lat_out_valid", out_valid, 1);
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) tick();
      tick();
      if (exp_q.size() != 0) begin
         note_fail("drain");
         exp_q.delete();
      end
   endtask

   task automatic wait_out_valid();
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk);
         seen = out_valid;
      end
      if (!seen) note_fail("out_valid_wait");
   endtask

   task automatic write_reg(input logic [AW-1:0] a, input logic [ACC_W:0] d, input bit exp_err);
      w_we   = 1'b1;
      w_addr = a;
      w_data = d;
      tick();
      w_we = 1'b0;
      @(negedge clk);
      check("w_err_pulse", w_err, exp_err);
      @(negedge clk);
      check("w_err_clear", w_err, 0);
      if (!exp_err) begin
         if (a < AW'(N_IN)) m_w[a] = d[W-1:0];
         else begin
            m_bneg = d[ACC_W];
            m_bmag = d[ACC_W-1:0];
         end
      end
      tick();
   endtask

   task automatic write_all_w(input logic [W-1:0] v0, input logic [W-1:0] v1,
                              input logic [W-1:0] v2, input logic [W-1:0] v3);
      write_reg(0, {1'b0, v0}, 0);
      write_reg(1, {1'b0, v1}, 0);
      write_reg(2, {1'b0, v2}, 0);
      write_reg(3, {1'b0, v3}, 0);
   endtask

   task automatic rand_xs(output logic [W-1:0] xs[N_IN]);
      for (int i = 0; i < N_IN; i++) xs[i] = W'($urandom_range(0, 65535));
   endtask

   task automatic check_reset_outputs();
      @(negedge clk);
      check("rst_in_ready",  in_ready,  1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum",   out_sum,   0);
      check("rst_out_sign",  out_sign,  0);
      check("rst_out_sat",   out_sat,   0);
      check("rst_w_err",     w_err,     0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0]   xs [N_IN];
      logic [W-1:0]   nw;
      logic [ACC_W:0] bv;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
      w_we = 1'b0; w_addr = '0; w_data = '0; out_ready = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_reset_outputs();
      tick();

      // unit weights, zero bias: 1.0 + 2.0 + 0.5 + 0.5
      write_all_w(16'h1000, 16'h1000, 16'h1000, 16'h1000);
      write_reg(AW'(N_IN), 17'h00000, 0);
      xs = '{16'h1000, 16'h2000, 16'h0800, 16'h0800};
      send_vec(xs, 0, 1);
      drain();

      // mixed signs, bias -0x100
      write_all_w(16'h1000, 16'h9000, 16'h0800, 16'h8800);
      write_reg(AW'(N_IN), 17'h10100, 0);
      xs = '{16'h2000, 16'h2000, 16'h2000, 16'h2000};
      send_vec(xs, 0, 1);
      drain();

      // exact zero with a negative-zero bias must not report negative
      write_reg(AW'(N_IN), 17'h10000, 0);
      send_vec(xs, 1, 0);
      drain();

      // saturation
      write_all_w(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      xs = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      send_vec(xs, 1, 1);
      drain();

      // backpressure: hold the result for 10 cycles
      write_all_w(16'h0400, 16'h8C00, 16'h1800, 16'h0100);
      out_ready = 1'b0;
      rand_xs(xs);
      send_vec(xs, 0, 0);
      wait_out_valid();
      repeat (10) begin
         @(negedge clk);
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready",  in_ready,  0);
         check("bp_out_sum",   out_sum,   exp_q[0][ACC_W-1:0]);
         check("bp_out_sign",  out_sign,  exp_q[0][ACC_W]);
      end
      tick();
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      check("bp_in_ready_back", in_ready,  1);
      check("bp_valid_dropped", out_valid, 0);
      tick();

      // write at count 2 is dropped; the vector keeps the old weight
      rand_xs(xs);
      exp_q.push_back(model_result(m_w, xs));
      n_vectors++;
      send_sample(xs[0]);
      send_sample(xs[1]);
      write_reg(0, 17'h01234, 1);
      send_sample(xs[2]);
      send_sample(xs[3]);
      drain();
      rand_xs(xs);
      send_vec(xs, 0, 0);
      drain();

      // out-of-range address at idle, and a write while a result waits
      write_reg(AW'(N_IN + 1), 17'h1FFFF, 1);
      out_ready = 1'b0;
      rand_xs(xs);
      send_vec(xs, 0, 0);
      wait_out_valid();
      tick();
      write_reg(1, 17'h07777, 1);
      out_ready = 1'b1;
      drain();

      // bias change at idle shifts the same vector's result
      rand_xs(xs);
      send_vec(xs, 0, 0);
      drain();
      write_reg(AW'(N_IN), 17'h00321, 0);
      send_vec(xs, 0, 0);
      drain();

      // write to w[0] on the same edge as the first sample: sample uses the old w[0]
      rand_xs(xs);
      nw = W'($urandom_range(0, 65535));
      exp_q.push_back(model_result(m_w, xs));
      n_vectors++;
      w_we = 1'b1; w_addr = '0; w_data = {1'b0, nw};
      send_sample(xs[0]);
      w_we = 1'b0;
      m_w[0] = nw;
      @(negedge clk);
      check("same_edge_w_err", w_err, 0);
      tick();
      for (int i = 1; i < N_IN; i++) send_sample(xs[i]);
      drain();
      rand_xs(xs);
      send_vec(xs, 1, 0);
      drain();

      // random weights, bias and samples
      for (int v = 0; v < 10; v++) begin
         for (int i = 0; i < N_IN; i++) begin
            nw = ($urandom_range(0, 5) == 0) ? 16'h8000 : W'($urandom_range(0, 65535));
            write_reg(AW'(i), {1'b0, nw}, 0);
         end
         bv = {1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535))};
         write_reg(AW'(N_IN), bv, 0);
         rand_xs(xs);
         send_vec(xs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         drain();
      end

      // async reset after 2 of 4 samples
      write_all_w(16'h1000, 16'h1000, 16'h1000, 16'h1000);
      send_sample(16'h4000);
      send_sample(16'h4000);
      #2 rst_n = 1'b0;
      #1 check("abort_out_valid", out_valid, 0);
      model_reset();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_in_ready",   in_ready,  1);
      check("abort_out_valid2", out_valid, 0);
      tick();
      rand_xs(xs);
      send_vec(xs, 0, 1);
      drain();

      // async reset while a result waits: out_valid drops at once
      write_all_w(16'h2000, 16'h0000, 16'h0000, 16'h0000);
      out_ready = 1'b0;
      rand_xs(xs);
      send_vec(xs, 0, 0);
      wait_out_valid();
      #1 rst_n = 1'b0;
      #1 check("rst_out_drop", out_valid, 0);
      exp_q.delete();
      model_reset();
      out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      check_reset_outputs();
      tick();
      rand_xs(xs);
      send_vec(xs, 1, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      note_fail("global_timeout");
      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
      $finish;
   end

endmodule
